// File: rtl/mcu_core_param.sv
// mcu_core_param: parametrised accumulator MCU core.
// Sequences fetch, decode and execute against an external memory with a
// ready handshake (unbounded wait states). Has zero and carry flags and a
// resumable HALT state.
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_mem_rdata           memory read data, sampled on read with i_mem_ready=1
//   i_mem_ready           memory completes the current access this cycle
//   i_resume              single-cycle pulse that leaves HALT
//   o_mem_wdata           write data (always the accumulator)
//   o_mem_addr            memory address
//   o_mem_rd, o_mem_wr    read / write strobes
//   o_mem_dout_en         bus drive enable (same as o_mem_wr)
//   o_acc_out             accumulator
//   o_zero, o_carry       flags
//   o_halted              core is in HALT
// DATA_W must be at least ADDR_W+3 so the opcode and operand fields fit.
module mcu_core_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ready,
   input  logic              i_resume,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd,
   output logic              o_mem_wr,
   output logic              o_mem_dout_en,
   output logic [DATA_W-1:0] o_acc_out,
   output logic              o_zero,
   output logic              o_carry,
   output logic              o_halted
);

   typedef enum logic [2:0] {
      StRst, StFetch, StDecode, StRead, StWrite, StHalt
   } state_e;

   typedef enum logic [2:0] {
      OpHlt = 3'b000, OpSkz = 3'b001, OpAdd = 3'b010, OpAnd = 3'b011,
      OpXor = 3'b100, OpLda = 3'b101, OpSto = 3'b110, OpJmp = 3'b111
   } op_e;

   localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

   state_e            r_state, w_state_d;
   logic [ADDR_W-1:0] r_pc, w_pc_d;
   logic [DATA_W-1:0] r_ir, w_ir_d;
   logic [DATA_W-1:0] r_acc, w_acc_d;
   logic              r_zero, w_zero_d;
   logic              r_carry, w_carry_d;

   op_e               w_opcode;
   logic [ADDR_W-1:0] w_operand;
   logic [DATA_W:0]   w_sum;
   logic              w_unused_ir;

   assign w_opcode    = op_e'(r_ir[DATA_W-1 -: 3]);
   assign w_operand   = r_ir[ADDR_W-1:0];
   // Bits between opcode and operand are ignored by the ISA.
   assign w_unused_ir = ^r_ir;
   // Extra top bit captures the carry-out of the add.
   assign w_sum       = {1'b0, r_acc} + {1'b0, i_mem_rdata};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StRst;
         r_pc    <= '0;
         r_ir    <= '0;
         r_acc   <= '0;
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
         r_ir    <= w_ir_d;
         r_acc   <= w_acc_d;
         r_zero  <= w_zero_d;
         r_carry <= w_carry_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_ir_d    = r_ir;
      w_acc_d   = r_acc;
      w_zero_d  = r_zero;
      w_carry_d = r_carry;
      unique case (r_state)
         StRst: w_state_d = StFetch;
         StFetch: begin
            if (i_mem_ready) begin
               w_ir_d    = i_mem_rdata;
               w_pc_d    = r_pc + PcOne;
               w_state_d = StDecode;
            end
         end
         StDecode: begin
            unique case (w_opcode)
               OpHlt: w_state_d = StHalt;
               OpSkz: begin
                  if (r_zero) w_pc_d = r_pc + PcOne;
                  w_state_d = StFetch;
               end
               OpJmp: begin
                  w_pc_d    = w_operand;
                  w_state_d = StFetch;
               end
               OpSto:   w_state_d = StWrite;
               default: w_state_d = StRead;
            endcase
         end
         StRead: begin
            if (i_mem_ready) begin
               unique case (w_opcode)
                  OpAdd: begin
                     w_acc_d   = w_sum[DATA_W-1:0];
                     w_carry_d = w_sum[DATA_W];
                  end
                  OpAnd:   w_acc_d = r_acc & i_mem_rdata;
                  OpXor:   w_acc_d = r_acc ^ i_mem_rdata;
                  default: w_acc_d = i_mem_rdata;
               endcase
               w_zero_d  = (w_acc_d == '0);
               w_state_d = StFetch;
            end
         end
         StWrite: begin
            if (i_mem_ready) w_state_d = StFetch;
         end
         StHalt: begin
            if (i_resume) w_state_d = StFetch;
         end
         default: w_state_d = StRst;
      endcase
   end

   // Strobes come from state alone so they fall as soon as reset forces StRst.
   always_comb begin
      o_mem_rd      = (r_state == StFetch) || (r_state == StRead);
      o_mem_wr      = (r_state == StWrite);
      o_mem_dout_en = o_mem_wr;
      o_mem_addr    = ((r_state == StRead) || (r_state == StWrite)) ? w_operand : r_pc;
      o_mem_wdata   = r_acc;
      o_halted      = (r_state == StHalt);
   end

   assign o_acc_out = r_acc;
   assign o_zero    = r_zero;
   assign o_carry   = r_carry;

endmodule
